board_loader: RTL and testbench
===============================

Name: board_loader

Overview:
- Sequencer that builds a playable 405-bit sudoku board from a stored solution map.
- Reads 81 solution cells serially from a synchronous map ROM and applies difficulty-dependent masking from a seeded LFSR.
- Drives the board image and a load-complete handshake consumed by the game state machine, replacing its direct parallel copy of the selected map.

Parameters:
CELLS, 81, cells per board (fixed 9x9)
CELL_W, 5, bits per cell: bit4 = given/revealed, bits3:0 = solution value
ROM_AW, 9, map ROM address width
DEFAULT_SEED, 16'hACE1, LFSR seed substituted when seed input is zero

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  load request, sampled only in IDLE
difficulty  input  1  0 = easy, 1 = hard; latched on accepted start
map_sel  input  2  map number 0..3; latched on accepted start
seed  input  16  LFSR seed; latched on accepted start
rom_addr  output  ROM_AW  map ROM address = map_sel*81 + cell index
rom_data  input  4  solution value; valid one cycle after rom_addr
board  output  405  board image; cell k at bits [k*5 +: 5], k = y*9 + x
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the board is complete
givens  output  7  number of cells written with bit4 = 1
rom_err  output  1  sticky flag: a ROM value outside 1..9 was read

Behaviour:
- Reset (async, reset low): state IDLE; board, rom_addr, givens = 0; busy, done, rom_err = 0; LFSR = DEFAULT_SEED; cell counter = 0.
- States: IDLE, PRIME, STREAM, FINISH.
- IDLE:
  - start = 1: latch difficulty and map_sel; LFSR <= seed, or DEFAULT_SEED if seed == 0.
  - Clear board, givens and rom_err; rom_addr <= map_sel*81; busy <= 1; go to PRIME.
- PRIME (1 cycle): rom_addr <= base + 1; go to STREAM; cell counter k = 0.
- STREAM (81 cycles, k = 0..80):
  - Each cycle, rom_data belongs to cell k.
  - hide = lfsr[1:0] == 2'b00 when easy (about 1/4 hidden), lfsr[0] == 0 when hard (about 1/2 hidden).
  - Write board[k*5 +: 5] <= {~hide, rom_data}.
  - Invalid value (0 or >9): write {1'b0, 4'd0}, set rom_err.
  - givens increments when bit4 written = 1.
  - Advance LFSR once: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit0.
  - rom_addr <= base + k + 2, saturating at base + 80 (no read beyond the map).
  - k == 80: go to FINISH.
- FINISH (1 cycle): done = 1, busy <= 0; return to IDLE.
- Latency: start accepted at edge 0; first cell written at edge 2; last cell at edge 82; done high in the cycle after edge 82, for exactly one cycle. Total 83 cycles.
- Hidden cells keep their solution value in bits3:0; the game checks guesses against it.
- start while busy: ignored. start held high across FINISH: the next load begins on the first IDLE cycle, never in FINISH itself.
- difficulty, map_sel and seed changing mid-load: no effect until the next accepted start.
- Reset mid-load: immediate abort to reset values; no done pulse.
- board is stable (only written cells change) during STREAM. It holds after done until the next accepted start.
- map_sel = 3: base = 243, highest address 323 (fits ROM_AW = 9).

Test Plan:
- Reset, then start with map_sel = 0, difficulty = 0, seed = 16'h0000, ROM cell k = (k % 9) + 1 -> busy rises on the next cycle; done is a single pulse exactly 83 cycles after start; every board cell has bits3:0 = (k % 9) + 1; bit4 pattern matches the golden LFSR from 16'hACE1; givens equals the popcount of bit4.
- Same ROM, seed = 16'h1234, difficulty = 1 -> hidden count matches the golden model for lfsr[0] == 0; rerunning with difficulty = 0 hides strictly the lfsr[1:0] == 0 subset of the same sequence.
- map_sel = 3 -> rom_addr runs 243..323, never exceeds 323, and is held at 323 during the final cycles.
- ROM returns 0 for cell 40 and 4'd12 for cell 41 -> both cells = 5'b00000; rom_err = 1 and stays set until the next accepted start; givens excludes them.
- start pulsed at cycle 30 of a load, and map_sel changed mid-load -> no restart and no change to addresses. Reset asserted low at cycle 50 -> board = 0, busy = 0, no done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/board_loader_if.sv
// Bus between the board loader, its solution-map ROM and the game state machine.
// Request: start is honoured only while busy is low; busy then stays high until the
// one-cycle done pulse, and board/givens/rom_err are final and stable from done onward.
interface board_loader_if #(
  parameter int ROM_AW = 9
);
  logic              start;
  logic              difficulty;
  logic [1:0]        map_sel;
  logic [15:0]       seed;
  logic [ROM_AW-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [404:0]      board;
  logic              busy;
  logic              done;
  logic [6:0]        givens;
  logic              rom_err;

  modport master (
    output start, difficulty, map_sel, seed, rom_data,
    input  rom_addr, board, busy, done, givens, rom_err
  );

  modport slave (
    input  start, difficulty, map_sel, seed, rom_data,
    output rom_addr, board, busy, done, givens, rom_err
  );
endinterface

// File: rtl/board_loader.sv
// Streams 81 solution cells from the map ROM into a board image, hiding cells
// according to a seeded LFSR and the latched difficulty.
module board_loader #(
  parameter int          ROM_AW       = 9,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  board_loader_if.slave  bus,
  output logic [1:0]     dbg_state_o
);

  localparam int CELLS  = 81;
  localparam int CELL_W = 5;
  localparam int BRD_W  = CELLS * CELL_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [6:0]        k_q, k_d;
  logic [ROM_AW-1:0] base_q, base_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              diff_q, diff_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [BRD_W-1:0]  board_q, board_d;
  logic [6:0]        givens_q, givens_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hide;
  logic              valid;
  logic [4:0]        cell_val;
  logic [8:0]        cell_lsb;
  logic [15:0]       lfsr_next;
  logic [ROM_AW-1:0] stream_addr;
  logic [ROM_AW-1:0] start_base;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign hide     = diff_q ? ~lfsr_q[0] : (lfsr_q[1:0] == 2'b00);
  assign valid    = (bus.rom_data != 4'd0) && (bus.rom_data <= 4'd9);
  assign cell_val = valid ? {~hide, bus.rom_data} : 5'd0;
  assign cell_lsb = {2'b00, k_q} * 9'd5;

  assign start_base = ROM_AW'(bus.map_sel) * ROM_AW'(CELLS);

  // Address runs one cell ahead of the data; it parks on the last cell of the map.
  assign stream_addr = (k_q >= 7'd78) ? base_q + ROM_AW'(CELLS - 1)
                                      : base_q + ROM_AW'(k_q) + ROM_AW'(2);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    addr_d   = addr_q;
    diff_d   = diff_q;
    lfsr_d   = lfsr_q;
    board_d  = board_q;
    givens_d = givens_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          diff_d   = bus.difficulty;
          base_d   = start_base;
          addr_d   = start_base;
          lfsr_d   = (bus.seed == 16'd0) ? DEFAULT_SEED : bus.seed;
          board_d  = '0;
          givens_d = 7'd0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_PRIME;
        end
      end
      S_PRIME: begin
        addr_d  = base_q + ROM_AW'(1);
        k_d     = 7'd0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        board_d[cell_lsb +: CELL_W] = cell_val;
        if (cell_val[4]) givens_d = givens_q + 7'd1;
        if (!valid) err_d = 1'b1;
        lfsr_d = lfsr_next;
        addr_d = stream_addr;
        if (k_q == 7'(CELLS - 1)) begin
          k_d     = 7'd0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= 7'd0;
      base_q   <= '0;
      addr_q   <= '0;
      diff_q   <= 1'b0;
      lfsr_q   <= DEFAULT_SEED;
      board_q  <= '0;
      givens_q <= 7'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      diff_q   <= diff_d;
      lfsr_q   <= lfsr_d;
      board_q  <= board_d;
      givens_q <= givens_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.board    = board_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.givens   = givens_q;
  assign bus.rom_err  = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader: a cycle-indexed model of each load is checked
// against the DUT outputs on every falling edge, plus hand-computed literal pins.
module tb_board_loader;
  localparam int CELLS = 81;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  board_loader_if #(.ROM_AW(9)) lb();

  board_loader #(.ROM_AW(9), .DEFAULT_SEED(16'hACE1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (lb.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] rom_mem [0:511];
  always @(posedge clk) lb.rom_data <= rom_mem[lb.rom_addr];

  // model state: 0 = idle, 1 = tracking a load, 2 = expect reset values
  int         m_mode = 2;
  int         m_t0 = 0;
  int         m_base = 0;
  logic [4:0] m_cells [CELLS];
  logic       m_bad   [CELLS];
  int         done_total = 0;
  int         done_base = 0;
  int         max_addr = 0;
  logic [404:0] exp_q[$];

  task automatic check(input string name, input logic [404:0] act, input logic [404:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic build_model(input int map, input logic diff, input logic [15:0] sd);
    logic [15:0] l;
    logic [3:0]  v;
    logic        hide;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    m_base = map * CELLS;
    for (int k = 0; k < CELLS; k++) begin
      v    = rom_mem[m_base + k];
      hide = diff ? (l[0] == 1'b0) : (l[1:0] == 2'b00);
      m_bad[k]   = (v < 4'd1) || (v > 4'd9);
      m_cells[k] = m_bad[k] ? 5'd0 : {~hide, v};
      l = lfsr_step(l);
    end
  endtask

  // scoreboard: n = rising edges since the accepting edge
  always @(negedge clk) begin
    int n, written, giv, ea;
    logic err;
    logic [404:0] eb;
    if (lb.done) done_total++;
    if (m_mode == 2) begin
      check("rst_busy",   405'(lb.busy),     405'(0));
      check("rst_done",   405'(lb.done),     405'(0));
      check("rst_addr",   405'(lb.rom_addr), 405'(0));
      check("rst_board",  lb.board,          405'(0));
      check("rst_givens", 405'(lb.givens),   405'(0));
      check("rst_err",    405'(lb.rom_err),  405'(0));
    end else if (m_mode == 1) begin
      n       = cyc - m_t0;
      written = (n < 2) ? 0 : ((n - 1 > CELLS) ? CELLS : n - 1);
      eb = '0; giv = 0; err = 1'b0;
      for (int k = 0; k < written; k++) begin
        eb[k*5 +: 5] = m_cells[k];
        if (m_cells[k][4]) giv++;
        if (m_bad[k]) err = 1'b1;
      end
      exp_q.push_back(eb);
      ea = (n == 0) ? m_base : m_base + ((n > 80) ? 80 : n);
      check("busy",   405'(lb.busy),     405'(n <= 82));
      check("done",   405'(lb.done),     405'(n == 82));
      check("addr",   405'(lb.rom_addr), 405'(ea));
      check("board",  lb.board,          exp_q.pop_front());
      check("givens", 405'(lb.givens),   405'(giv));
      check("rom_err",405'(lb.rom_err),  405'(err));
      if (n == 0 || int'(lb.rom_addr) > max_addr) max_addr = int'(lb.rom_addr);
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int map, input logic diff, input logic [15:0] sd);
    m_mode = 0;
    build_model(map, diff, sd);
    lb.map_sel    = 2'(map);
    lb.difficulty = diff;
    lb.seed       = sd;
    lb.start      = 1'b1;
    @(posedge clk);
    #1;
    m_t0      = cyc;
    done_base = done_total;
    m_mode    = 1;
    lb.start  = 1'b0;
  endtask

  task automatic expect_one_done(input string name);
    check(name, 405'(done_total - done_base), 405'(1));
  endtask

  logic [404:0] hard_board;
  logic [29:0]  pin_cells;
  int eh, hh, viol;

  initial begin
    lb.start = 1'b0; lb.difficulty = 1'b0; lb.map_sel = 2'd0; lb.seed = 16'd0;
    for (int a = 0; a < 512; a++) rom_mem[a] = 4'hF;
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < CELLS; k++) rom_mem[m*CELLS + k] = 4'(((k + m) % 9) + 1);

    tick(3);
    reset = 1'b1;
    tick(2);

    check("pin_lfsr_step", 405'(lfsr_step(16'hACE1)), 405'(16'h59C3));

    // zero seed falls back to ACE1, easy, map 0
    launch(0, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++) pin_cells[k*5 +: 5] = m_cells[k];
    check("pin_model_easy", 405'(pin_cells), 405'({5'h06, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11}));
    tick(90);
    expect_one_done("done_pulse_l1");
    check("l1_cells0_5", 405'(lb.board[29:0]), 405'({5'h06, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11}));

    // hard then easy with the same seed: easy hides a strict subset
    launch(0, 1'b1, 16'h1234);
    tick(90);
    expect_one_done("done_pulse_hard");
    check("hard_cells0_2", 405'(lb.board[14:0]), 405'({5'h03, 5'h12, 5'h01}));
    hard_board = lb.board;
    launch(0, 1'b0, 16'h1234);
    tick(90);
    expect_one_done("done_pulse_easy");
    check("easy_cells0_2", 405'(lb.board[14:0]), 405'({5'h13, 5'h12, 5'h01}));
    eh = 0; hh = 0; viol = 0;
    for (int k = 0; k < CELLS; k++) begin
      if (!lb.board[k*5+4]) eh++;
      if (!hard_board[k*5+4]) hh++;
      if (!lb.board[k*5+4] && hard_board[k*5+4]) viol++;
    end
    check("subset_viol", 405'(viol), 405'(0));
    check("easy_fewer_hidden", 405'(eh < hh), 405'(1));

    // map 3 reaches the top of the ROM and parks there
    launch(3, 1'b1, 16'hBEEF);
    tick(90);
    expect_one_done("done_pulse_map3");
    check("map3_max_addr", 405'(max_addr), 405'(323));
    check("map3_final_addr", 405'(lb.rom_addr), 405'(323));

    // invalid ROM values on cells 40 and 41 of map 1
    rom_mem[CELLS + 40] = 4'd0;
    rom_mem[CELLS + 41] = 4'd12;
    launch(1, 1'b0, 16'h5A5A);
    tick(90);
    expect_one_done("done_pulse_err");
    check("err_cells40_41", 405'(lb.board[209:200]), 405'(0));
    check("err_flag", 405'(lb.rom_err), 405'(1));

    // start held high across FINISH: next load starts on the first IDLE cycle
    launch(2, 1'b0, 16'h0001);
    tick(81);
    lb.start = 1'b1;
    tick(2);
    expect_one_done("done_pulse_held");
    launch(2, 1'b1, 16'h0F0F);
    tick(90);
    expect_one_done("done_pulse_after_held");

    // start and selections disturbed mid-load must not matter
    launch(1, 1'b1, 16'h00FF);
    tick(30);
    lb.start = 1'b1; lb.map_sel = 2'd3; lb.difficulty = 1'b0; lb.seed = 16'h1111;
    tick(1);
    lb.start = 1'b0;
    tick(60);
    expect_one_done("done_pulse_disturbed");

    // reset mid-load aborts without a done pulse
    launch(0, 1'b0, 16'hC0DE);
    tick(50);
    reset  = 1'b0;
    m_mode = 2;
    tick(5);
    reset = 1'b1;
    tick(3);
    check("abort_no_done", 405'(done_total - done_base), 405'(0));
    launch(0, 1'b0, 16'hC0DE);
    tick(90);
    expect_one_done("done_pulse_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
